// File: rtl/gnor_pkg.sv
// gnor_pkg: shared constants for the gnor_pipe reduction stage.
//   MODE_* : 2-bit gate select codes carried alongside each input beat.
package gnor_pkg;

    localparam logic [1:0] MODE_NOR  = 2'b00;
    localparam logic [1:0] MODE_OR   = 2'b01;
    localparam logic [1:0] MODE_NAND = 2'b10;
    localparam logic [1:0] MODE_AND  = 2'b11;

endpackage

// File: rtl/gnor_lane.sv
// gnor_lane: combinational WIDTH-input reduction gate with run-time function.
// Ports:
//   bits [WIDTH-1:0] in  : lane inputs
//   mode [1:0]       in  : gate select (NOR/OR/NAND/AND, see gnor_pkg)
//   res              out : reduced result
module gnor_lane
    import gnor_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] bits,
    input  logic [1:0]       mode,
    output logic             res
);

    always_comb begin
        res = ~|bits;
        case (mode)
            MODE_NOR:  res = ~|bits;
            MODE_OR:   res = |bits;
            MODE_NAND: res = ~&bits;
            MODE_AND:  res = &bits;
            default:   res = ~|bits;
        endcase
    end

endmodule

// File: rtl/gnor_pipe.sv
// gnor_pipe: CHANNELS-lane logic reduction stage with a registered
// valid/ready output and per-lane saturating rise counters.
// Ports:
//   clk, rst              : clock (rising edge), async active-high reset
//   in_valid / in_ready   : input handshake (in_ready is combinational)
//   in_data               : lane c at [c*WIDTH +: WIDTH]
//   mode                  : gate select, sampled with the accepted beat
//   out_valid / out_ready : output handshake
//   y                     : registered per-lane result
//   clr_cnt               : synchronous clear of all rise counters
//   rise_cnt              : lane c counter at [c*CNT_W +: CNT_W]
module gnor_pipe
    import gnor_pkg::*;
#(
    parameter int WIDTH    = 2,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [1:0]                mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS-1:0]       y,
    input  logic                      clr_cnt,
    output logic [CHANNELS*CNT_W-1:0] rise_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CHANNELS-1:0] lane_res;
    logic [CHANNELS-1:0] y_reg;
    logic [CHANNELS-1:0] prev_y_reg;
    logic                out_valid_reg;
    logic                accept;
    logic                deliver;

    // A slot is free when empty or being drained this cycle; this gives
    // full throughput without a combinational path from in_valid.
    assign in_ready  = !out_valid_reg || out_ready;
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid_reg && out_ready;
    assign out_valid = out_valid_reg;
    assign y         = y_reg;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
            gnor_lane #(
                .WIDTH(WIDTH)
            ) u_lane (
                .bits(in_data[gi*WIDTH +: WIDTH]),
                .mode(mode),
                .res (lane_res[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            y_reg         <= '0;
            prev_y_reg    <= '0;
        end else begin
            if (accept) begin
                y_reg         <= lane_res;
                out_valid_reg <= 1'b1;
            end else if (deliver) begin
                // y keeps its last value after draining
                out_valid_reg <= 1'b0;
            end
            if (deliver) begin
                prev_y_reg <= y_reg;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            logic             rise;

            // rise is judged on the beat leaving now versus the last delivered beat
            assign rise = deliver && !prev_y_reg[gi] && y_reg[gi];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (clr_cnt) begin
                    cnt_reg <= '0;
                end else if (rise && (cnt_reg != CNT_MAX)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign rise_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
        end
    endgenerate

endmodule

// File: tb/tb_gnor_pipe.sv
// tb_gnor_pipe: directed self-checking bench for gnor_pipe. A second
// instance with CNT_W=2 shares all stimulus to observe counter saturation.
module tb_gnor_pipe;
    import gnor_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  y;
    logic        clr_cnt;
    logic [31:0] rise_cnt;

    logic        in_ready_s;
    logic        out_valid_s;
    logic [3:0]  y_s;
    logic [7:0]  rise_cnt_s;

    int n_checks;
    int n_fail;

    gnor_pipe #(.WIDTH(2), .CHANNELS(4), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .mode     (mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .clr_cnt  (clr_cnt),
        .rise_cnt (rise_cnt)
    );

    gnor_pipe #(.WIDTH(2), .CHANNELS(4), .CNT_W(2)) dut_sat (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready_s),
        .in_data  (in_data),
        .mode     (mode),
        .out_valid(out_valid_s),
        .out_ready(out_ready),
        .y        (y_s),
        .clr_cnt  (clr_cnt),
        .rise_cnt (rise_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // one clock edge, then settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // reference: lane c of 4 lanes of 2 bits
    function automatic logic [3:0] ref_gate(input logic [7:0] d, input logic [1:0] m);
        logic [3:0] r;
        logic [1:0] b;
        for (int c = 0; c < 4; c++) begin
            b = d[c*2 +: 2];
            case (m)
                2'b00:   r[c] = (b == 2'b00);
                2'b01:   r[c] = (b != 2'b00);
                2'b10:   r[c] = (b != 2'b11);
                default: r[c] = (b == 2'b11);
            endcase
        end
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic [1:0] m;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        mode      = MODE_NOR;
        out_ready = 1'b1;
        clr_cnt   = 1'b0;

        // reset state
        repeat (2) step();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_y", {28'd0, y}, 32'd0);
        check("rst_rise_cnt", rise_cnt, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;

        // truth table, lanes = 11,10,01,00
        in_valid = 1'b1;
        in_data  = 8'hE4;
        mode = MODE_NOR;  step();
        check("tt_nor", {28'd0, y}, 32'h1);
        check("tt_nor_valid", {31'd0, out_valid}, 32'd1);
        mode = MODE_OR;   step();
        check("tt_or", {28'd0, y}, 32'hE);
        mode = MODE_NAND; step();
        check("tt_nand", {28'd0, y}, 32'h7);
        mode = MODE_AND;  step();
        check("tt_and", {28'd0, y}, 32'h8);
        in_valid = 1'b0;  step();
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        check("drain_y_hold", {28'd0, y}, 32'h8);

        // backpressure: A held while B waits
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h00;
        mode      = MODE_NOR;
        step();
        check("bp_a_loaded", {28'd0, y}, 32'hF);
        in_data = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("bp_hold_y%0d", i), {28'd0, y}, 32'hF);
            check($sformatf("bp_hold_rdy%0d", i), {31'd0, in_ready}, 32'd0);
            check($sformatf("bp_hold_vld%0d", i), {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        step();
        check("bp_b_loaded", {28'd0, y}, 32'h0);
        check("bp_b_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        step();
        check("bp_b_drained", {31'd0, out_valid}, 32'd0);

        // clear counters (nothing delivered this cycle; prev_y is now 0)
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        check("clr_main", rise_cnt, 32'd0);
        check("clr_sat", {24'd0, rise_cnt_s}, 32'd0);

        // rises: deliver F,0,F,0,F (NOR of 00 -> F, of FF -> 0)
        in_valid = 1'b1;
        mode     = MODE_NOR;
        for (int i = 0; i < 5; i++) begin
            in_data = (i % 2 == 0) ? 8'h00 : 8'hFF;
            step();
        end
        in_valid = 1'b0;
        step();
        check("rise3_main", rise_cnt, 32'h03030303);
        check("rise3_sat", {24'd0, rise_cnt_s}, 32'hFF);

        // two more rises: 0,F,0,F
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = (i % 2 == 0) ? 8'hFF : 8'h00;
            step();
        end
        in_valid = 1'b0;
        step();
        check("rise5_main", rise_cnt, 32'h05050505);
        check("rise5_sat", {24'd0, rise_cnt_s}, 32'hFF);

        // clr_cnt coinciding with a rising deliver
        in_valid = 1'b1;
        in_data  = 8'hFF;
        step();
        in_data  = 8'h00;
        step();
        in_valid = 1'b0;
        clr_cnt  = 1'b1;
        step();
        clr_cnt  = 1'b0;
        check("clr_win_main", rise_cnt, 32'd0);
        check("clr_win_sat", {24'd0, rise_cnt_s}, 32'd0);
        // same value again: prev_y already F, no rise
        in_valid = 1'b1;
        in_data  = 8'h00;
        step();
        in_valid = 1'b0;
        step();
        check("no_rise_after_clr", rise_cnt, 32'd0);

        // one rise per lane, then stall with y=A and reset asynchronously
        in_valid = 1'b1;
        in_data  = 8'hFF;
        step();
        in_data  = 8'h00;
        step();
        in_valid = 1'b0;
        step();
        check("pre_rst_cnt", rise_cnt, 32'h01010101);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h33;
        step();
        in_valid = 1'b0;
        check("stall_y_a", {28'd0, y}, 32'hA);
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_y", {28'd0, y}, 32'd0);
        check("async_rst_cnt", rise_cnt, 32'd0);
        check("async_rst_ready", {31'd0, in_ready}, 32'd1);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hE4;
        mode      = MODE_OR;
        step();
        check("post_rst_y", {28'd0, y}, 32'hE);
        check("post_rst_valid", {31'd0, out_valid}, 32'd1);

        // streaming: random beats back to back
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            m = 2'($urandom_range(0, 3));
            in_data = d;
            mode    = m;
            step();
            check($sformatf("stream%0d_y", i), {28'd0, y}, {28'd0, ref_gate(d, m)});
            check($sformatf("stream%0d_vld", i), {31'd0, out_valid & in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drained", {31'd0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
